// File: rtl/data_mem_resp.sv
// Data-memory responder: word-addressed RAM with wait states and a busy/ready handshake.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module data_mem_resp #(
  parameter int unsigned MEM_DEPTH_LOG2 = 12,
  parameter int unsigned WAIT_CYCLES    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_mem_req_i,
  input  logic                  data_mem_wr_en_i,
  input  logic [`CPU_WIDTH-1:0] data_mem_addr_i,
  input  logic [`CPU_WIDTH-1:0] data_mem_data_i,
  output logic [`CPU_WIDTH-1:0] data_mem_data_o,
  output logic                  data_mem_busy_o,
  output logic                  data_mem_ready_o,
  output logic                  data_mem_err_o
);

  localparam int unsigned Depth = 2 ** MEM_DEPTH_LOG2;

  typedef enum logic [2:0] {StIdle, StWait, StRead, StWrite, StDone} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                      wr_q, wr_d;
  logic                      oor_q, oor_d;
  logic [`CPU_WIDTH-1:0]     rdata_q;
  logic [`CPU_WIDTH-1:0]     mem [Depth];

  logic                      req_oor;
  logic [MEM_DEPTH_LOG2-1:0] req_idx;
  logic                      unused_addr_lsb;

  assign req_oor         = |data_mem_addr_i[`CPU_WIDTH-1:MEM_DEPTH_LOG2+2];
  assign req_idx         = data_mem_addr_i[MEM_DEPTH_LOG2+1:2];
  // Byte lanes are resolved by the core.
  assign unused_addr_lsb = ^data_mem_addr_i[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_q == StRead) begin
      rdata_q <= oor_q ? '0 : mem[idx_q];
    end
  end

  // Reset at the WRITE edge suppresses the store.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == StWrite) && !oor_q) begin
      mem[idx_q] <= data_mem_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    oor_d   = oor_q;
    unique case (state_q)
      StIdle: begin
        if (data_mem_req_i) begin
          idx_d   = req_idx;
          wr_d    = data_mem_wr_en_i;
          oor_d   = req_oor;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? StWait : StRead;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StRead;
        end
      end
      StRead:  state_d = wr_q ? StWrite : StDone;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign data_mem_data_o  = rdata_q;
  assign data_mem_busy_o  = rst_n && (((state_q == StIdle) && data_mem_req_i) ||
                                      (state_q == StWait) || (state_q == StRead) ||
                                      (state_q == StWrite));
  assign data_mem_ready_o = (state_q == StDone);
  assign data_mem_err_o   = (state_q == StDone) && oor_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed, table-driven bench for data_mem_resp with WAIT_CYCLES of 1, 0 and 15.
module tb_data_mem_resp;

  logic        clk;
  logic        rst_n;
  logic        req1, req0, req15;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] data1, data0, data15;
  logic        busy1, busy0, busy15;
  logic        rdy1, rdy0, rdy15;
  logic        err1, err0, err15;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_resp #(.MEM_DEPTH_LOG2(12), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .data_mem_req_i(req1), .data_mem_wr_en_i(wr_en),
    .data_mem_addr_i(addr), .data_mem_data_i(wdata), .data_mem_data_o(data1),
    .data_mem_busy_o(busy1), .data_mem_ready_o(rdy1), .data_mem_err_o(err1)
  );

  data_mem_resp #(.MEM_DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .data_mem_req_i(req0), .data_mem_wr_en_i(wr_en),
    .data_mem_addr_i(addr), .data_mem_data_i(wdata), .data_mem_data_o(data0),
    .data_mem_busy_o(busy0), .data_mem_ready_o(rdy0), .data_mem_err_o(err0)
  );

  data_mem_resp #(.MEM_DEPTH_LOG2(12), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst_n(rst_n), .data_mem_req_i(req15), .data_mem_wr_en_i(wr_en),
    .data_mem_addr_i(addr), .data_mem_data_i(wdata), .data_mem_data_o(data15),
    .data_mem_busy_o(busy15), .data_mem_ready_o(rdy15), .data_mem_err_o(err15)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          sel;       // 0: W=1, 1: W=0, 2: W=15
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_cyc;
    logic        chk_data;  // load: data at ready; store: old word seen in WRITE
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [31:0] d, output logic b, output logic r,
                        output logic e);
    case (sel)
      0:       begin d = data1;  b = busy1;  r = rdy1;  e = err1;  end
      1:       begin d = data0;  b = busy0;  r = rdy0;  e = err0;  end
      default: begin d = data15; b = busy15; r = rdy15; e = err15; end
    endcase
  endtask

  // Issue one request (req held for cycle 0 only) and follow it to ready.
  task automatic run_access(input int sel, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, output int rdy_cyc,
                            output logic [31:0] d_rdy, output logic [31:0] d_prev,
                            output logic e_rdy, output logic busy_ok);
    logic [31:0] d;
    logic        b, r, e;
    int          cyc;
    wr_en   = wr;
    addr    = a;
    wdata   = wd;
    req1    = (sel == 0);
    req0    = (sel == 1);
    req15   = (sel == 2);
    cyc     = 0;
    rdy_cyc = -1;
    busy_ok = 1'b1;
    d_rdy   = '0;
    d_prev  = '0;
    e_rdy   = 1'b0;
    while (cyc <= 40) begin
      @(negedge clk);
      sample(sel, d, b, r, e);
      if (r) begin
        rdy_cyc = cyc;
        d_rdy   = d;
        e_rdy   = e;
        if (b) busy_ok = 1'b0;
        break;
      end
      if (!b) busy_ok = 1'b0;
      d_prev = d;
      @(posedge clk);
      #1;
      req1  = 1'b0;
      req0  = 1'b0;
      req15 = 1'b0;
      cyc++;
    end
    req1  = 1'b0;
    req0  = 1'b0;
    req15 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          rc;
    logic [31:0] dr, dp;
    logic        er, bok;
    string       nm;

    vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4, 1'b0, 32'h0,           1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         3, 1'b1, 32'hDEAD_BEEF,   1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4, 1'b1, 32'hDEAD_BEEF,   1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0011, 32'h1122_AA44, 4, 1'b1, 32'h1122_3344,   1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0012, 32'h0,         3, 1'b1, 32'h1122_AA44,   1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4, 1'b0, 32'h0,           1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4, 1'b1, 32'h0,           1'b1});
    vecs.push_back('{0, 1'b0, 32'h0000_4000, 32'h0,         3, 1'b1, 32'h0,           1'b1});
    vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         3, 1'b1, 32'h0BAD_F00D,   1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_3FFC, 32'h55AA_55AA, 4, 1'b0, 32'h0,           1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_3FFF, 32'h0,         3, 1'b1, 32'h55AA_55AA,   1'b0});
    vecs.push_back('{0, 1'b0, 32'h8000_0010, 32'h0,         3, 1'b1, 32'h0,           1'b1});
    vecs.push_back('{1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 3, 1'b0, 32'h0,           1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0020, 32'h0,         2, 1'b1, 32'hA5A5_A5A5,   1'b0});
    vecs.push_back('{2, 1'b1, 32'h0000_0020, 32'h1234_5678, 18, 1'b0, 32'h0,          1'b0});
    vecs.push_back('{2, 1'b0, 32'h0000_0020, 32'h0,         17, 1'b1, 32'h1234_5678,  1'b0});

    // Reset held with a pending request: nothing may move.
    rst_n = 1'b0;
    req1  = 1'b1;
    req0  = 1'b0;
    req15 = 1'b0;
    wr_en = 1'b0;
    addr  = 32'h0000_0010;
    wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy1}, 32'h0);
    chk("reset_ready", {31'b0, rdy1}, 32'h0);
    chk("reset_data", data1, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req1  = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {31'b0, busy1}, 32'h0);
    chk("post_reset_ready", {31'b0, rdy1}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_access(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rc, dr, dp, er, bok);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_ready_cycle"}, 32'(rc), 32'(vecs[i].exp_cyc));
      chk({nm, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
      chk({nm, "_busy_until_done"}, {31'b0, bok}, 32'h1);
      if (vecs[i].chk_data) begin
        chk({nm, "_data"}, vecs[i].wr ? dp : dr, vecs[i].exp_data);
      end
    end

    // Reset asserted in the WRITE cycle of a store to word 4 (currently 0x1122AA44).
    wr_en = 1'b1;
    addr  = 32'h0000_0010;
    wdata = 32'hFFFF_FFFF;
    req1  = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("write_cycle_old_word", data1, 32'h1122_AA44);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_ready%0d", k), {31'b0, rdy1}, 32'h0);
      @(posedge clk);
      #1;
    end
    run_access(0, 1'b0, 32'h0000_0010, 32'h0, rc, dr, dp, er, bok);
    chk("abort_ready_cycle", 32'(rc), 32'd3);
    chk("abort_mem_unchanged", dr, 32'h1122_AA44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
